// File: rtl/fifo_wptr_full.sv
`timescale 1ns/1ps
// Write-domain pointer, full flag and occupancy for the async FIFO (FIFO_ALMOST_FULL_EN adds w_almost_full).
// Latency: outputs registered one w_clk after w_inc; a read-pointer move reaches w_full/w_count on the 3rd edge.
// Backpressure: w_full blocks w_inc; writes while full are dropped and the pointers hold.
module fifo_wptr_full #(
  parameter int Addr_size = 9,
  parameter int AF_LEVEL  = 500
) (
  input  logic                 w_clk,
  input  logic                 w_rst,
  input  logic                 w_inc,
  input  logic [Addr_size:0]   rptr,
  output logic [Addr_size-1:0] waddr,
  output logic [Addr_size:0]   wptr,
  output logic                 w_full,
  output logic [Addr_size:0]   w_count
`ifdef FIFO_ALMOST_FULL_EN
  ,
  output logic                 w_almost_full
`endif
);

  localparam int MSB = Addr_size;

  logic [MSB:0] wbin;
  logic [MSB:0] wbinnext;
  logic [MSB:0] wgraynext;
  logic [MSB:0] wq1_rptr;
  logic [MSB:0] wq2_rptr;
  logic [MSB:0] rbin_sync;
  logic [MSB:0] occ_next;
  logic         winc_ok;
  logic         full_next;

  // Plain two-flop synchronizer; nothing else may touch rptr.
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      wq1_rptr <= '0;
      wq2_rptr <= '0;
    end else begin
      wq1_rptr <= rptr;
      wq2_rptr <= wq1_rptr;
    end
  end

  assign winc_ok   = w_inc & ~w_full;
  assign wbinnext  = wbin + {{MSB{1'b0}}, winc_ok};
  assign wgraynext = (wbinnext >> 1) ^ wbinnext;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    rbin_sync = '0;
    for (int i = 0; i <= MSB; i++) begin
      rbin_sync[i] = ^(wq2_rptr >> i);
    end
  end

  assign occ_next  = wbinnext - rbin_sync;
  assign full_next = (wgraynext == {~wq2_rptr[MSB:MSB-1], wq2_rptr[MSB-2:0]});
  assign waddr     = wbin[MSB-1:0];

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      wbin    <= '0;
      wptr    <= '0;
      w_full  <= 1'b0;
      w_count <= '0;
    end else begin
      wbin    <= wbinnext;
      wptr    <= wgraynext;
      w_full  <= full_next;
      w_count <= occ_next;
    end
  end

`ifdef FIFO_ALMOST_FULL_EN
  localparam logic [MSB:0] AF_THR = (MSB+1)'(AF_LEVEL);

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      w_almost_full <= 1'b0;
    end else begin
      w_almost_full <= (occ_next >= AF_THR);
    end
  end
`endif

endmodule
